// File: rtl/jtsdram_bank_chk_if.sv
// jtsdram_bank_chk_if: romrq-style read port between the bank checker
// (master) and the bank's jtframe_romrq plus the reference pattern model (slave).
interface jtsdram_bank_chk_if #(
   parameter int AW = 22,
   parameter int DW = 16
);
   logic [AW-1:0] cnt_addr;   // address under test
   logic          cs;         // read request, address valid
   logic          data_ok;    // romrq data-ready strobe
   logic [DW-1:0] dout;       // data returned by romrq
   logic [DW-1:0] data_ref;   // expected word for cnt_addr (combinational from model)

   modport master (
      output cnt_addr, cs,
      input  data_ok, dout, data_ref
   );

   modport slave (
      input  cnt_addr, cs,
      output data_ok, dout, data_ref
   );
endinterface

// File: rtl/jtsdram_bank_chk.sv
// jtsdram_bank_chk: read-back checker for one SDRAM bank.
// Sweeps [addr_first, addr_last] up or down, one romrq read per address,
// compares every word against the model reference and records error count,
// first failing address/data and a per-access timeout.
// Optional macro JTSDRAM_CHK_STOP_EN: when defined the first mismatch ends the
// sweep; when undefined the whole window is always covered.
module jtsdram_bank_chk #(
   parameter int AW   = 22,
   parameter int DW   = 16,
   parameter int ERRW = 8,
   parameter int GAPW = 4,
   parameter int TOW  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dir,
   input  logic [AW-1:0]   addr_first,
   input  logic [AW-1:0]   addr_last,
   input  logic            slow,
   input  logic            LVBL,
   jtsdram_bank_chk_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            bad,
   output logic [ERRW-1:0] err_cnt,
   output logic [AW-1:0]   err_addr,
   output logic [DW-1:0]   err_data,
   output logic            timeout
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GAP  = 3'd1,
      REQ  = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   state_t          state_q,    state_d;
   logic            dir_q,      dir_d;
   logic [AW-1:0]   first_q,    first_d;
   logic [AW-1:0]   last_q,     last_d;
   logic [AW-1:0]   cnt_addr_q, cnt_addr_d;
   logic            cs_q,       cs_d;
   logic            busy_q,     busy_d;
   logic            done_q,     done_d;
   logic            bad_q,      bad_d;
   logic [ERRW-1:0] err_cnt_q,  err_cnt_d;
   logic [AW-1:0]   err_addr_q, err_addr_d;
   logic [DW-1:0]   err_data_q, err_data_d;
   logic            timeout_q,  timeout_d;
   logic [15:0]     lfsr_q,     lfsr_d;
   logic [GAPW-1:0] gap_q,      gap_d;
   logic [TOW-1:0]  wdog_q,     wdog_d;
   logic [DW-1:0]   dout_r_q,   dout_r_d;
   logic [DW-1:0]   dref_r_q,   dref_r_d;

   logic            mismatch;
   logic            stop_on_err;
   logic            gap_leave;
   logic [AW-1:0]   end_addr;

   // Next-state and datapath: start overrides everything, then per-state work
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      first_d    = first_q;
      last_d     = last_q;
      cnt_addr_d = cnt_addr_q;
      cs_d       = cs_q;
      busy_d     = busy_q;
      done_d     = done_q;
      bad_d      = bad_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      err_data_d = err_data_q;
      timeout_d  = timeout_q;
      gap_d      = gap_q;
      wdog_d     = wdog_q;
      dout_r_d   = dout_r_q;
      dref_r_d   = dref_r_q;
      // Fibonacci LFSR, taps 16,14,13,11, free running
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      // 4-state compare: X/Z on the returned word is reported as a mismatch
      mismatch   = (dout_r_q !== dref_r_q);
`ifdef JTSDRAM_CHK_STOP_EN
      stop_on_err = mismatch;
`else
      stop_on_err = 1'b0;
`endif
      gap_leave  = slow ? (gap_q == '0) : LVBL;
      end_addr   = dir_q ? first_q : last_q;

      if (start) begin
         dir_d      = dir;
         first_d    = addr_first;
         last_d     = addr_last;
         cnt_addr_d = dir ? addr_last : addr_first;
         bad_d      = 1'b0;
         err_cnt_d  = '0;
         err_addr_d = '0;
         err_data_d = '0;
         timeout_d  = 1'b0;
         done_d     = 1'b0;
         cs_d       = 1'b0;
         wdog_d     = '0;
         gap_d      = '0;
         if (addr_first > addr_last) begin
            // empty window: finish without issuing any read
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
         end else begin
            busy_d  = 1'b1;
            state_d = GAP;
         end
      end else begin
         case (state_q)
            IDLE: ;
            GAP: begin
               cs_d = 1'b0;
               if (gap_leave) begin
                  cs_d    = 1'b1;
                  wdog_d  = '0;
                  state_d = REQ;
               end else if (slow) begin
                  gap_d = gap_q - 1'b1;
               end
            end
            REQ: begin
               // wdog_q==0 marks the first REQ cycle: a strobe there may be
               // left over from the previous access, so it is not accepted
               if (wdog_q != '0 && bus.data_ok) begin
                  cs_d     = 1'b0;
                  dout_r_d = bus.dout;
                  dref_r_d = bus.data_ref;
                  state_d  = CHK;
               end else if (wdog_q == {TOW{1'b1}}) begin
                  timeout_d = 1'b1;
                  cs_d      = 1'b0;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  state_d   = DONE;
               end else begin
                  wdog_d = wdog_q + 1'b1;
               end
            end
            CHK: begin
               if (mismatch) begin
                  bad_d = 1'b1;
                  if (err_cnt_q != {ERRW{1'b1}})
                     err_cnt_d = err_cnt_q + 1'b1;
                  // bad_q still low means this is the first error since start
                  if (!bad_q) begin
                     err_addr_d = cnt_addr_q;
                     err_data_d = dout_r_q;
                  end
               end
               if (cnt_addr_q == end_addr || stop_on_err) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  cnt_addr_d = dir_q ? cnt_addr_q - 1'b1 : cnt_addr_q + 1'b1;
                  gap_d      = slow ? lfsr_q[GAPW-1:0] : '0;
                  state_d    = GAP;
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         dir_q      <= 1'b0;
         first_q    <= '0;
         last_q     <= '0;
         cnt_addr_q <= '0;
         cs_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bad_q      <= 1'b0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         err_data_q <= '0;
         timeout_q  <= 1'b0;
         lfsr_q     <= LFSR_SEED;
         gap_q      <= '0;
         wdog_q     <= '0;
         dout_r_q   <= '0;
         dref_r_q   <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         first_q    <= first_d;
         last_q     <= last_d;
         cnt_addr_q <= cnt_addr_d;
         cs_q       <= cs_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bad_q      <= bad_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         err_data_q <= err_data_d;
         timeout_q  <= timeout_d;
         lfsr_q     <= lfsr_d;
         gap_q      <= gap_d;
         wdog_q     <= wdog_d;
         dout_r_q   <= dout_r_d;
         dref_r_q   <= dref_r_d;
      end
   end

   assign bus.cnt_addr = cnt_addr_q;
   assign bus.cs       = cs_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign bad          = bad_q;
   assign err_cnt      = err_cnt_q;
   assign err_addr     = err_addr_q;
   assign err_data     = err_data_q;
   assign timeout      = timeout_q;

endmodule
